// File: rtl/wrr_arb_pkg.sv
// Shared types, defaults and helpers for the weighted round-robin arbiter.
// Holds the FSM state enum and the rotated first-set search.
package wrr_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        RELOAD
    } state_t;

    localparam int DEF_NUM_REQUESTS = 4;
    localparam int DEF_WEIGHT_W     = 4;
    localparam int DEF_MAX_HOLD     = 16;

    // Index of the first set bit of vec[n-1:0], scanning upward from ptr
    // and wrapping at n. Returns 0 when nothing is set.
    function automatic int unsigned first_set_rot(
        input logic [31:0] vec,
        input int unsigned n,
        input int unsigned ptr
    );
        int unsigned idx;
        logic        hit;
        first_set_rot = 0;
        hit = 1'b0;
        for (int unsigned k = 0; k < 32; k++) begin
            if (!hit && k < n) begin
                idx = ptr + k;
                if (idx >= n)
                    idx = idx - n;
                if (|(vec & (32'd1 << idx))) begin
                    hit = 1'b1;
                    first_set_rot = idx;
                end
            end
        end
    endfunction

endpackage

// File: rtl/wrr_credit_arbiter_rr_pick.sv
// Combinational rotating-priority picker.
// Ports: eligible (candidates), pointer (start index) -> onehot, found.
module rr_pick
    import wrr_arb_pkg::*;
#(
    parameter int N  = DEF_NUM_REQUESTS,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  eligible,
    input  logic [PW-1:0] pointer,
    output logic [N-1:0]  onehot,
    output logic          found
);

    always_comb begin
        onehot = '0;
        found  = |eligible;
        if (found)
            onehot[PW'(first_set_rot(32'(eligible), N, 32'(pointer)))] = 1'b1;
    end

endmodule

// File: rtl/wrr_credit_arbiter.sv
// Weighted round-robin arbiter with per-requester credits; a grant is
// held for a whole transaction until done or the request drops.
// Ports: clk, reset (sync, active-high), req, done, weight (packed)
//        -> grant (one-hot), grant_id, busy, timeout.
// Optional macro GRANT_TIMEOUT_EN: revoke a grant after MAX_HOLD cycles.
module wrr_credit_arbiter
    import wrr_arb_pkg::*;
#(
    parameter int NUM_REQUESTS = DEF_NUM_REQUESTS,
    parameter int WEIGHT_W     = DEF_WEIGHT_W,
    parameter int MAX_HOLD     = DEF_MAX_HOLD
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_REQUESTS-1:0]          req,
    input  logic [NUM_REQUESTS-1:0]          done,
    input  logic [NUM_REQUESTS*WEIGHT_W-1:0] weight,
    output logic [NUM_REQUESTS-1:0]          grant,
    output logic [$clog2(NUM_REQUESTS)-1:0]  grant_id,
    output logic                             busy,
    output logic                             timeout
);

    localparam int IDW = $clog2(NUM_REQUESTS);
    localparam logic [IDW-1:0] LAST = IDW'(NUM_REQUESTS - 1);

    state_t                state;
    logic [IDW-1:0]        pointer;
    logic [WEIGHT_W-1:0]   credit [NUM_REQUESTS];
    logic [NUM_REQUESTS-1:0] eligible;
    logic [NUM_REQUESTS-1:0] armed;
    logic [NUM_REQUESTS-1:0] pick;
    logic [IDW-1:0]        pick_id;
    logic                  found;
    logic                  rel;
    logic                  expire;

    // armed: a live request whose weight is non-zero; only these may
    // trigger a credit reload, so disabled requesters stay inert.
    always_comb begin
        eligible = '0;
        armed    = '0;
        for (int i = 0; i < NUM_REQUESTS; i++) begin
            eligible[i] = req[i] && (credit[i] != '0);
            armed[i]    = req[i] &&
                          (weight[i*WEIGHT_W +: WEIGHT_W] != '0);
        end
    end

    rr_pick #(
        .N  (NUM_REQUESTS),
        .PW (IDW)
    ) u_pick (
        .eligible (eligible),
        .pointer  (pointer),
        .onehot   (pick),
        .found    (found)
    );

    always_comb begin
        pick_id = '0;
        for (int i = 0; i < NUM_REQUESTS; i++)
            if (pick[i])
                pick_id = IDW'(i);
    end

    // A dropped request releases the grant just like done.
    assign rel = done[grant_id] | ~req[grant_id];

`ifdef GRANT_TIMEOUT_EN
    localparam int HW = $clog2(MAX_HOLD + 1);
    logic [HW-1:0] hold;
    assign expire = (hold == HW'(MAX_HOLD - 1));
`else
    // No forced revoke in this build; a grant lasts until released.
    assign expire = (MAX_HOLD < 0);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            grant    <= '0;
            grant_id <= '0;
            busy     <= 1'b0;
            timeout  <= 1'b0;
            pointer  <= '0;
            for (int i = 0; i < NUM_REQUESTS; i++)
                credit[i] <= weight[i*WEIGHT_W +: WEIGHT_W];
`ifdef GRANT_TIMEOUT_EN
            hold     <= '0;
`endif
        end else begin
            timeout <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (found) begin
                        grant    <= pick;
                        grant_id <= pick_id;
                        busy     <= 1'b1;
                        state    <= GRANT;
`ifdef GRANT_TIMEOUT_EN
                        hold     <= '0;
`endif
                    end else if (|armed) begin
                        state <= RELOAD;
                    end
                end
                RELOAD: begin
                    for (int i = 0; i < NUM_REQUESTS; i++)
                        credit[i] <= weight[i*WEIGHT_W +: WEIGHT_W];
                    state <= IDLE;
                end
                GRANT: begin
                    if (rel || expire) begin
                        grant <= '0;
                        busy  <= 1'b0;
                        credit[grant_id] <= (credit[grant_id] == '0) ? '0 :
                                            credit[grant_id] - WEIGHT_W'(1);
                        pointer <= (grant_id == LAST) ? '0 :
                                   grant_id + IDW'(1);
                        // done wins over a coincident expiry
                        timeout <= ~rel;
                        state   <= IDLE;
                    end
`ifdef GRANT_TIMEOUT_EN
                    else begin
                        hold <= hold + HW'(1);
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wrr_credit_arbiter.sv
// Directed bench for wrr_credit_arbiter: a vector table plus hand-written
// multi-cycle sequences (disable, release by drop, reset, timeout).
module tb_wrr_credit_arbiter;

    localparam int N  = 4;
    localparam int WW = 4;
    localparam int MH = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  req;
    logic [N-1:0]  done;
    logic [N*WW-1:0] weight;
    logic [N-1:0]  grant;
    logic [1:0]    grant_id;
    logic          busy;
    logic          timeout;

    always #5 clk = ~clk;

    wrr_credit_arbiter #(
        .NUM_REQUESTS (N),
        .WEIGHT_W     (WW),
        .MAX_HOLD     (MH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .done     (done),
        .weight   (weight),
        .grant    (grant),
        .grant_id (grant_id),
        .busy     (busy),
        .timeout  (timeout)
    );

    typedef struct {
        logic        rst;
        logic [3:0]  rq;
        logic [3:0]  dn;
        logic [15:0] w;
        logic [3:0]  g;
    } vec_t;

    vec_t tab[$];
    int   nvec = 0;
    int   nerr = 0;

    function automatic void add(input logic rs, input logic [3:0] rq,
                                input logic [3:0] dn, input logic [15:0] w,
                                input logic [3:0] g);
        vec_t v;
        v.rst = rs;
        v.rq  = rq;
        v.dn  = dn;
        v.w   = w;
        v.g   = g;
        tab.push_back(v);
    endfunction

    function automatic logic [1:0] enc(input logic [3:0] g);
        enc = 2'd0;
        for (int i = 0; i < 4; i++)
            if (g[i])
                enc = 2'(i);
    endfunction

    // One clock: drive on the falling edge, sample 1 ns after the rise.
    task automatic cyc(input logic rs, input logic [3:0] rq,
                       input logic [3:0] dn, input logic [15:0] w);
        @(negedge clk);
        reset  = rs;
        req    = rq;
        done   = dn;
        weight = w;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [3:0] g,
                       input logic tmo);
        nvec++;
        if (grant !== g || busy !== (|g) || timeout !== tmo ||
            ((|g) && grant_id !== enc(g))) begin
            nerr++;
            $display("FAIL %s: got grant=%b busy=%b id=%0d timeout=%b, want grant=%b busy=%b id=%0d timeout=%b",
                     nm, grant, busy, grant_id, timeout,
                     g, |g, enc(g), tmo);
        end
    endtask

    logic [15:0] w;

    initial begin
        reset  = 1'b1;
        req    = '0;
        done   = '0;
        weight = 16'h1111;

        // Equal weights: 0,1,2,3, one RELOAD cycle, then 0,1
        w = 16'h1111;
        add(1, 4'h0, 4'h0, w, 4'h0);
        for (int i = 0; i < 4; i++) begin
            logic [3:0] g;
            g = 4'(1 << i);
            add(0, 4'hF, 4'h0, w, g);
            add(0, 4'hF, 4'h0, w, g);
            add(0, 4'hF, 4'h0, w, g);
            add(0, 4'hF, g,    w, 4'h0);
        end
        add(0, 4'hF, 4'h0, w, 4'h0);
        add(0, 4'hF, 4'h0, w, 4'h0);
        add(0, 4'hF, 4'h0, w, 4'h1);
        add(0, 4'hF, 4'h0, w, 4'h1);
        add(0, 4'hF, 4'h0, w, 4'h1);
        add(0, 4'hF, 4'h1, w, 4'h0);
        add(0, 4'hF, 4'h0, w, 4'h2);

        // Unequal weights w0=3 w1=1: 0,1,0,0, RELOAD, 1,0,0,0, RELOAD, 1
        w = 16'h0013;
        add(1, 4'h0, 4'h0, w, 4'h0);
        add(0, 4'h3, 4'h0, w, 4'h1);
        add(0, 4'h3, 4'h1, w, 4'h0);
        add(0, 4'h3, 4'h0, w, 4'h2);
        add(0, 4'h3, 4'h2, w, 4'h0);
        add(0, 4'h3, 4'h0, w, 4'h1);
        add(0, 4'h3, 4'h1, w, 4'h0);
        add(0, 4'h3, 4'h0, w, 4'h1);
        add(0, 4'h3, 4'h1, w, 4'h0);
        add(0, 4'h3, 4'h0, w, 4'h0);
        add(0, 4'h3, 4'h0, w, 4'h0);
        add(0, 4'h3, 4'h0, w, 4'h2);
        add(0, 4'h3, 4'h2, w, 4'h0);
        for (int i = 0; i < 3; i++) begin
            add(0, 4'h3, 4'h0, w, 4'h1);
            add(0, 4'h3, 4'h1, w, 4'h0);
        end
        add(0, 4'h3, 4'h0, w, 4'h0);
        add(0, 4'h3, 4'h0, w, 4'h0);
        add(0, 4'h3, 4'h0, w, 4'h2);

        for (int i = 0; i < tab.size(); i++) begin
            cyc(tab[i].rst, tab[i].rq, tab[i].dn, tab[i].w);
            chk($sformatf("tab%0d", i), tab[i].g, 1'b0);
        end

        // Disabled requester 2: no grant and no reload. Credit 0 of
        // requester 0 is spent first, so a spurious reload would show up
        // as an early grant to 0 afterwards.
        w = 16'h1011;
        cyc(1, 4'h0, 4'h0, w); chk("dis_rst", 4'h0, 1'b0);
        cyc(0, 4'h1, 4'h0, w); chk("dis_g0", 4'h1, 1'b0);
        cyc(0, 4'h1, 4'h1, w); chk("dis_rel0", 4'h0, 1'b0);
        for (int i = 0; i < 50; i++) begin
            cyc(0, 4'h4, 4'h0, w);
            chk("dis_idle", 4'h0, 1'b0);
        end
        cyc(0, 4'h1, 4'h0, w); chk("dis_rl_a", 4'h0, 1'b0);
        cyc(0, 4'h1, 4'h0, w); chk("dis_rl_b", 4'h0, 1'b0);
        cyc(0, 4'h1, 4'h0, w); chk("dis_g0b", 4'h1, 1'b0);
        cyc(0, 4'h1, 4'h1, w); chk("dis_rel", 4'h0, 1'b0);

        // Release by request drop: credit[1] spent, pointer moves to 2
        w = 16'h1111;
        cyc(1, 4'h0, 4'h0, w); chk("drop_rst", 4'h0, 1'b0);
        cyc(0, 4'h2, 4'h0, w); chk("drop_g1", 4'h2, 1'b0);
        cyc(0, 4'h0, 4'h0, w); chk("drop_rel", 4'h0, 1'b0);
        cyc(0, 4'hF, 4'h0, w); chk("drop_ptr", 4'h4, 1'b0);
        cyc(0, 4'hF, 4'h4, w); chk("drop_rel2", 4'h0, 1'b0);
        cyc(0, 4'h2, 4'h0, w); chk("drop_cr_a", 4'h0, 1'b0);
        cyc(0, 4'h2, 4'h0, w); chk("drop_cr_b", 4'h0, 1'b0);
        cyc(0, 4'h2, 4'h0, w); chk("drop_cr_g", 4'h2, 1'b0);

        // Reset mid-grant reloads from the weights seen during reset
        // (2 each); the later change back to 1 is ignored until RELOAD.
        cyc(1, 4'h0, 4'h0, 16'h1111); chk("mid_rst0", 4'h0, 1'b0);
        cyc(0, 4'h1, 4'h0, 16'h1111); chk("mid_g0", 4'h1, 1'b0);
        cyc(1, 4'h1, 4'h0, 16'h2222); chk("mid_rst", 4'h0, 1'b0);
        cyc(0, 4'h1, 4'h0, 16'h1111); chk("mid_g1", 4'h1, 1'b0);
        cyc(0, 4'h1, 4'h1, 16'h1111); chk("mid_r1", 4'h0, 1'b0);
        cyc(0, 4'h1, 4'h0, 16'h1111); chk("mid_g2", 4'h1, 1'b0);
        cyc(0, 4'h1, 4'h1, 16'h1111); chk("mid_r2", 4'h0, 1'b0);
        cyc(0, 4'h1, 4'h0, 16'h1111); chk("mid_rl_a", 4'h0, 1'b0);
        cyc(0, 4'h1, 4'h0, 16'h1111); chk("mid_rl_b", 4'h0, 1'b0);
        cyc(0, 4'h1, 4'h0, 16'h1111); chk("mid_g3", 4'h1, 1'b0);

`ifdef GRANT_TIMEOUT_EN
        // Held grant to 3 is revoked after MH cycles with a timeout pulse
        cyc(1, 4'h0, 4'h0, w); chk("to_rst", 4'h0, 1'b0);
        cyc(0, 4'h8, 4'h0, w); chk("to_g3", 4'h8, 1'b0);
        for (int i = 0; i < MH - 1; i++) begin
            cyc(0, 4'h8, 4'h0, w);
            chk("to_hold", 4'h8, 1'b0);
        end
        cyc(0, 4'h8, 4'h0, w); chk("to_revoke", 4'h0, 1'b1);
        cyc(0, 4'h0, 4'h0, w); chk("to_pulse", 4'h0, 1'b0);
        // done in the last hold cycle wins over the expiry
        cyc(1, 4'h0, 4'h0, w); chk("tod_rst", 4'h0, 1'b0);
        cyc(0, 4'h8, 4'h0, w); chk("tod_g3", 4'h8, 1'b0);
        for (int i = 0; i < MH - 1; i++) begin
            cyc(0, 4'h8, 4'h0, w);
            chk("tod_hold", 4'h8, 1'b0);
        end
        cyc(0, 4'h8, 4'h8, w); chk("tod_done", 4'h0, 1'b0);
        cyc(0, 4'h0, 4'h0, w); chk("tod_after", 4'h0, 1'b0);
`else
        // Without the timeout feature a grant is held indefinitely
        cyc(1, 4'h0, 4'h0, w); chk("hold_rst", 4'h0, 1'b0);
        cyc(0, 4'h8, 4'h0, w); chk("hold_g3", 4'h8, 1'b0);
        for (int i = 0; i < 3 * MH; i++) begin
            cyc(0, 4'h8, 4'h0, w);
            chk("hold_long", 4'h8, 1'b0);
        end
        cyc(0, 4'h8, 4'h8, w); chk("hold_done", 4'h0, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
